// File: rtl/pc_redirect.sv
// Fetch PC sequencer: sequential advance, stall hold, one-cycle branch/jump redirect with IF/ID flush.
// Optional macro REDIRECT_COUNT_EN enables the free-running redirect counter on RedirectCount.
//
// state    | meaning
// ST_RUN   | normal fetch, execute-stage redirects accepted
// ST_FLUSH | cycle after a redirect, wrong-path execute instruction ignored
module pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h1000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        ExValid,
  input  logic        ExBranch,
  input  logic        ExJump,
  input  logic        Diverge,
  input  logic [31:0] BranchTarget,
  output logic [31:0] PC,
  output logic        FlushIF,
  output logic        FlushID,
  output logic        Redirect,
  output logic        MisalignedTarget,
  output logic [31:0] RedirectCount
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_misaligned;
  logic        w_take;

  // Reset suppresses the redirect even if execute qualifies one in the same cycle.
  assign w_take = ExValid & (r_state == ST_RUN) & (ExJump | (ExBranch & Diverge)) & ~Reset;

  assign Redirect         = w_take;
  assign FlushIF          = w_take | Reset;
  assign FlushID          = w_take | Reset;
  assign PC               = r_pc;
  assign MisalignedTarget = r_misaligned;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_take) begin
            r_state      <= ST_FLUSH;
            r_pc         <= {BranchTarget[31:2], 2'b00};
            r_misaligned <= |BranchTarget[1:0];
          end else begin
            r_state      <= ST_RUN;
            r_misaligned <= 1'b0;
            if (!Stall) r_pc <= r_pc + 32'd4;
          end
        end
        ST_FLUSH: begin
          r_state      <= ST_RUN;
          r_misaligned <= 1'b0;
          if (!Stall) r_pc <= r_pc + 32'd4;
        end
        default: begin
          r_state      <= ST_RUN;
          r_misaligned <= 1'b0;
        end
      endcase
    end
  end

`ifdef REDIRECT_COUNT_EN
  logic [31:0] r_redirect_count;

  always_ff @(posedge Clock) begin
    if (Reset) r_redirect_count <= 32'h0;
    else if (w_take) r_redirect_count <= r_redirect_count + 32'd1;
  end

  assign RedirectCount = r_redirect_count;
`else
  assign RedirectCount = 32'h0;
`endif

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1000_0000, meaning the fetch address loaded on Reset.
REQ-002 SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous active-high reset, sampled on the Clock rising edge.
REQ-004 SHALL have port Stall  input  1  hold the fetch PC (hazard or memory wait).
REQ-005 SHALL have port ExValid  input  1  execute stage holds a live instruction.
REQ-006 SHALL have port ExBranch  input  1  execute instruction is a conditional branch (OPC_BRANCH).
REQ-007 SHALL have port ExJump  input  1  execute instruction is JAL/JALR.
REQ-008 SHALL have port Diverge  input  1  branch-condition result from BranchControl.
REQ-009 SHALL have port BranchTarget  input  32  redirect address computed in execute.
REQ-010 SHALL have port PC  output  32  current fetch address.
REQ-011 SHALL have port FlushIF  output  1  kill the instruction in IF.
REQ-012 SHALL have port FlushID  output  1  kill the instruction in ID.
REQ-013 SHALL have port Redirect  output  1  redirect taken this cycle.
REQ-014 SHALL have port MisalignedTarget  output  1  registered pulse: last redirect target had bits [1:0] nonzero.
REQ-015 SHALL have port RedirectCount  output  32  count of redirects taken.

Function
REQ-016 SHALL define take = ExValid & state==RUN & (ExJump | (ExBranch & Diverge)); Redirect, FlushIF, FlushID SHALL equal take combinationally, same cycle.
REQ-017 SHALL, on take, load PC <= {BranchTarget[31:2],2'b00} at the next edge; take SHALL override Stall.
REQ-018 SHALL, with no take and Stall=1, hold PC unchanged; with no take and Stall=0, load PC <= PC+4.
REQ-019 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-020 SHALL implement two states: RUN and FLUSH; RUN->FLUSH on take; FLUSH->RUN unconditionally after one cycle.
REQ-021 SHALL, in FLUSH, ignore ExValid/ExBranch/ExJump/Diverge (wrong-path instruction reaching execute); PC advances or holds per Stall only.
REQ-022 SHALL set MisalignedTarget=1 for exactly the cycle after a take whose BranchTarget[1:0]!=0, else 0.
REQ-023 SHALL keep ExBranch with Diverge=0 as no redirect; ExBranch & ExJump both 1 SHALL redirect.
REQ-024 SHALL give one-cycle redirect latency: target appears on PC the cycle after take.

Reset
REQ-025 SHALL, on Reset, set PC=RESET_PC, state=RUN, MisalignedTarget=0, RedirectCount=0.
REQ-026 SHALL force FlushIF=FlushID=1 and Redirect=0 while Reset=1, including Reset mid-FLUSH or coincident with take (Reset wins, no redirect).

Configuration
REQ-027 SHALL, with REDIRECT_COUNT_EN defined, increment RedirectCount by 1 per take, wrapping at 2^32.
REQ-028 SHALL, without REDIRECT_COUNT_EN, tie RedirectCount to 32'h0 with no counter logic; all other behaviour identical.

Verification
REQ-029 Reset 2 cycles, then Stall=0 for 3 cycles -> PC 32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C; FlushIF/FlushID=1 during Reset only.
REQ-030 ExValid=ExBranch=Diverge=1, BranchTarget=32'h1000_0100, Stall=1 -> Redirect/FlushIF/FlushID=1 same cycle; next PC=32'h1000_0100; state FLUSH.
REQ-031 Take immediately followed by ExValid=ExJump=1 in FLUSH cycle, target 32'h2000_0000 -> second ignored; PC=target1+4; RedirectCount=1 with macro, 0 without.
REQ-032 ExBranch=1, Diverge=0 -> Redirect=0, PC+4; then ExJump=1, BranchTarget=32'h1000_0042 -> PC=32'h1000_0040, MisalignedTarget=1 for one cycle.
REQ-033 PC forced to 32'hFFFF_FFFC via jump, Stall=0 -> next PC=32'h0000_0000.
REQ-034 Reset asserted in same cycle as a take -> PC=RESET_PC, Redirect=0, state RUN, RedirectCount=0.
